// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for debug/loader (x), data (d) and fetch (i) requesters.
// One access per cycle; read data returned to the owning requester one cycle after grant.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  x_req,
  input  logic                  x_we,
  input  logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [31:0]           x_wdata,
  output logic                  x_gnt,
  output logic [31:0]           x_rdata,
  output logic                  x_rvalid,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic [31:0]           d_rdata,
  output logic                  d_rvalid,

  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic [31:0]           i_rdata,
  output logic                  i_rvalid,

  output logic                  m_en,
  output logic                  m_we,
  output logic [3:0]            m_be,
  output logic [ADDR_WIDTH-3:0] m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_X    = 2'd1,
    OWN_D    = 2'd2,
    OWN_I    = 2'd3
  } owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       starve;
  owner_t     owner_q;
  owner_t     owner_d;

  // Byte-offset bits never reach the word-addressed RAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{x_addr[1:0], d_addr[1:0], i_addr[1:0]};

  assign starve = (wait_cnt == WAIT_MAX);

  // Grants depend only on requests and registered state, and are held off during reset.
  always_comb begin
    x_gnt = 1'b0;
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (reset) begin
      if (x_req) begin
        x_gnt = 1'b1;
      end else if (d_req && !(i_req && starve)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    owner_d = OWN_NONE;
    if (x_gnt) begin
      m_en    = 1'b1;
      m_we    = x_we;
      m_be    = '1;
      m_addr  = x_addr[ADDR_WIDTH-1:2];
      m_wdata = x_wdata;
      owner_d = x_we ? OWN_NONE : OWN_X;
    end else if (d_gnt) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr[ADDR_WIDTH-1:2];
      m_wdata = d_wdata;
      owner_d = d_we ? OWN_NONE : OWN_D;
    end else if (i_gnt) begin
      m_en    = 1'b1;
      m_be    = '1;
      m_addr  = i_addr[ADDR_WIDTH-1:2];
      owner_d = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
      if (i_req && !i_gnt) begin
        if (wait_cnt < WAIT_MAX) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    x_rvalid = (owner_q == OWN_X);
    d_rvalid = (owner_q == OWN_D);
    i_rvalid = (owner_q == OWN_I);
    x_rdata  = x_rvalid ? m_rdata : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;
    i_rdata  = i_rvalid ? m_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a word-array RAM model and a priority/counter reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        x_req, x_we;
  logic [31:0] x_addr, x_wdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        i_req;
  logic [31:0] i_addr;

  logic        x_gnt, x_rvalid, d_gnt, d_rvalid, i_gnt, i_rvalid;
  logic [31:0] x_rdata, d_rdata, i_rdata;
  logic        m_en, m_we;
  logic [3:0]  m_be;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  logic        x1_gnt, d1_gnt, i1_gnt;
  logic        unused_x1_rvalid, unused_d1_rvalid, unused_i1_rvalid;
  logic [31:0] unused_x1_rdata, unused_d1_rdata, unused_i1_rdata;
  logic        unused_m1_en, unused_m1_we;
  logic [3:0]  unused_m1_be;
  logic [29:0] unused_m1_addr;
  logic [31:0] unused_m1_wdata;

  mem_port_arbiter #(.ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rdata(x_rdata), .x_rvalid(x_rvalid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .MAX_WAIT(1)) dut1 (
    .clk(clk), .reset(reset),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x1_gnt), .x_rdata(unused_x1_rdata), .x_rvalid(unused_x1_rvalid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d1_gnt), .d_rdata(unused_d1_rdata), .d_rvalid(unused_d1_rvalid),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i1_gnt), .i_rdata(unused_i1_rdata), .i_rvalid(unused_i1_rvalid),
    .m_en(unused_m1_en), .m_we(unused_m1_we), .m_be(unused_m1_be),
    .m_addr(unused_m1_addr), .m_wdata(unused_m1_wdata),
    .m_rdata(32'h0)
  );

  function automatic logic [31:0] init_word(int i);
    logic [31:0] v;
    v = (32'(i) * 32'h0001_0203) ^ 32'hA500_0000;
    if (i == 41) v = 32'h0000_0013;
    return v;
  endfunction

  // RAM environment: synchronous read, byte-enabled write
  logic [31:0] ram [0:255];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ram[m_addr[7:0]][b*8 +: 8] <= m_wdata[b*8 +: 8];
      end else begin
        m_rdata <= ram[m_addr[7:0]];
      end
    end
  end

  // Reference model state
  int          tests = 0;
  int          fails = 0;
  int          exp_cnt = 0;
  int          exp_cnt1 = 0;
  int          exp_owner = 0;
  logic [31:0] exp_rd = '0;
  logic [31:0] shadow [0:255];

  function automatic int exp_winner(int cnt, int mw);
    if (!reset) return 0;
    if (x_req) return 1;
    if (d_req && i_req) return (cnt == mw) ? 3 : 2;
    if (d_req) return 2;
    if (i_req) return 3;
    return 0;
  endfunction

  function automatic logic [2:0] gvec(int w);
    case (w)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic advance();
    int w, w1;
    logic [7:0] idx;
    w  = exp_winner(exp_cnt, 4);
    w1 = exp_winner(exp_cnt1, 1);
    @(posedge clk);
    if (!reset) begin
      exp_cnt = 0; exp_cnt1 = 0; exp_owner = 0;
    end else begin
      exp_cnt  = (i_req && w != 3)  ? ((exp_cnt < 4) ? exp_cnt + 1 : 4) : 0;
      exp_cnt1 = (i_req && w1 != 3) ? 1 : 0;
      exp_owner = 0;
      case (w)
        1: begin
          idx = x_addr[9:2];
          if (x_we) shadow[idx] = x_wdata;
          else begin exp_owner = 1; exp_rd = shadow[idx]; end
        end
        2: begin
          idx = d_addr[9:2];
          if (d_we) begin
            for (int b = 0; b < 4; b++)
              if (d_be[b]) shadow[idx][b*8 +: 8] = d_wdata[b*8 +: 8];
          end else begin exp_owner = 2; exp_rd = shadow[idx]; end
        end
        3: begin
          idx = i_addr[9:2];
          exp_owner = 3; exp_rd = shadow[idx];
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    x_req = 1'b0; d_req = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    x_req = 1'b1; x_we = 1'b0; x_addr = 32'h0; x_wdata = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h80;
    repeat (3) begin
      @(negedge clk); #1;
      tests++;
      if ({x_gnt, d_gnt, i_gnt} !== 3'b000) begin
        fails++; $display("FAIL reset_gnt: got %b want 000", {x_gnt, d_gnt, i_gnt});
      end
      tests++;
      if ({x_rvalid, d_rvalid, i_rvalid, m_en} !== 4'b0000) begin
        fails++; $display("FAIL reset_rvalid_men: got %b want 0000", {x_rvalid, d_rvalid, i_rvalid, m_en});
      end
      tests++;
      if ({m_we, m_be, m_addr, m_wdata} !== '0 || {x_rdata, d_rdata, i_rdata} !== '0) begin
        fails++; $display("FAIL reset_mbus: got we=%b be=%h addr=%h wd=%h want all 0", m_we, m_be, m_addr, m_wdata);
      end
      advance();
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({x_gnt, d_gnt, i_gnt, m_en} !== 4'b1001) begin
      fails++; $display("FAIL reset_release_xgnt: got %b want 1001", {x_gnt, d_gnt, i_gnt, m_en});
    end
    advance();
  endtask

  task automatic test_fetch();
    @(negedge clk);
    idle(); i_req = 1'b1; i_addr = 32'h0000_00A4;
    #1;
    tests++;
    if ({x_gnt, d_gnt, i_gnt} !== 3'b001 || m_addr !== 30'h29 || m_be !== 4'hF || m_we !== 1'b0) begin
      fails++; $display("FAIL fetch_cmd: got gnt=%b addr=%h be=%h we=%b want 001/29/f/0",
                        {x_gnt, d_gnt, i_gnt}, m_addr, m_be, m_we);
    end
    advance();
    @(negedge clk);
    i_req = 1'b0;
    #1;
    tests++;
    if ({x_rvalid, d_rvalid, i_rvalid} !== 3'b001 || i_rdata !== 32'h0000_0013) begin
      fails++; $display("FAIL fetch_resp: got rv=%b rdata=%h want 001/00000013", {x_rvalid, d_rvalid, i_rvalid}, i_rdata);
    end
    advance();
  endtask

  task automatic test_starvation();
    logic [2:0] e, e1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) begin
        idle(); d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
        i_req = 1'b1; i_addr = 32'h200;
      end
      #1;
      e  = (k % 5 == 4) ? 3'b001 : 3'b010;
      e1 = (k % 2 == 1) ? 3'b001 : 3'b010;
      tests++;
      if ({x_gnt, d_gnt, i_gnt} !== e) begin
        fails++; $display("FAIL starve_period5 k=%0d: got %b want %b", k, {x_gnt, d_gnt, i_gnt}, e);
      end
      tests++;
      if ({x1_gnt, d1_gnt, i1_gnt} !== e1) begin
        fails++; $display("FAIL starve_alternate k=%0d: got %b want %b", k, {x1_gnt, d1_gnt, i1_gnt}, e1);
      end
      advance();
    end
    // flag now set; x still wins and the counter must stay saturated
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      x_req = (k < 2); x_we = 1'b0; x_addr = 32'h300;
      #1;
      e = (k < 2) ? 3'b100 : 3'b001;
      tests++;
      if ({x_gnt, d_gnt, i_gnt} !== e || {x1_gnt, d1_gnt, i1_gnt} !== e) begin
        fails++; $display("FAIL starve_x_override k=%0d: got %b/%b want %b", k,
                          {x_gnt, d_gnt, i_gnt}, {x1_gnt, d1_gnt, i1_gnt}, e);
      end
      advance();
    end
  endtask

  task automatic test_data_write();
    @(negedge clk);
    idle(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h10; d_wdata = 32'h0000_AB00;
    #1;
    tests++;
    if ({x_gnt, d_gnt, i_gnt} !== 3'b010 || m_we !== 1'b1 || m_be !== 4'b0010 ||
        m_addr !== 30'h4 || m_wdata !== 32'h0000_AB00) begin
      fails++; $display("FAIL dwrite_cmd: got gnt=%b we=%b be=%b addr=%h wd=%h want 010/1/0010/4/0000ab00",
                        {x_gnt, d_gnt, i_gnt}, m_we, m_be, m_addr, m_wdata);
    end
    advance();
    @(negedge clk);
    d_we = 1'b0; d_be = 4'hF;
    #1;
    tests++;
    if (d_rvalid !== 1'b0 || d_gnt !== 1'b1) begin
      fails++; $display("FAIL dwrite_no_rvalid: got rvalid=%b gnt=%b want 0/1", d_rvalid, d_gnt);
    end
    advance();
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata[15:8] !== 8'hAB || d_rdata !== exp_rd) begin
      fails++; $display("FAIL dread_after_write: got rvalid=%b rdata=%h want 1/%h", d_rvalid, d_rdata, exp_rd);
    end
    advance();
  endtask

  task automatic test_loader();
    logic [31:0] loaded [0:7];
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      idle(); i_req = 1'b1; i_addr = 32'h0;
      x_req = 1'b1; x_we = 1'b1; x_addr = 32'(w * 4);
      loaded[w] = $urandom; x_wdata = loaded[w];
      #1;
      tests++;
      if ({x_gnt, d_gnt, i_gnt} !== 3'b100) begin
        fails++; $display("FAIL loader_hold_fetch w=%0d: got %b want 100", w, {x_gnt, d_gnt, i_gnt});
      end
      advance();
    end
    @(negedge clk);
    x_req = 1'b0;
    #1;
    tests++;
    if ({x_gnt, d_gnt, i_gnt} !== 3'b001) begin
      fails++; $display("FAIL loader_fetch_gnt: got %b want 001", {x_gnt, d_gnt, i_gnt});
    end
    advance();
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (i_rvalid !== 1'b1 || i_rdata !== loaded[0]) begin
      fails++; $display("FAIL loader_fetch_data: got rvalid=%b rdata=%h want 1/%h", i_rvalid, i_rdata, loaded[0]);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle(); d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h10;
      i_req = 1'b1; i_addr = 32'h20;
      #1;
      tests++;
      if ({x_gnt, d_gnt, i_gnt} !== 3'b010) begin
        fails++; $display("FAIL rstmid_pre k=%0d: got %b want 010", k, {x_gnt, d_gnt, i_gnt});
      end
      advance();
    end
    @(negedge clk);
    reset = 1'b0;
    exp_owner = 0; exp_cnt = 0; exp_cnt1 = 0;
    #1;
    tests++;
    if (d_rvalid !== 1'b0 || {x_gnt, d_gnt, i_gnt} !== 3'b000) begin
      fails++; $display("FAIL rstmid_drop: got rvalid=%b gnt=%b want 0/000", d_rvalid, {x_gnt, d_gnt, i_gnt});
    end
    advance();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) reset = 1'b1;
      #1;
      if (k == 0) begin
        tests++;
        if (d_rvalid !== 1'b0) begin
          fails++; $display("FAIL rstmid_no_rvalid: got %b want 0", d_rvalid);
        end
      end
      e = (k < 4) ? 3'b010 : 3'b001;
      tests++;
      if ({x_gnt, d_gnt, i_gnt} !== e) begin
        fails++; $display("FAIL rstmid_cnt_cleared k=%0d: got %b want %b", k, {x_gnt, d_gnt, i_gnt}, e);
      end
      advance();
    end
    @(negedge clk);
    idle();
    advance();
  endtask

  task automatic test_random();
    int w, w1, last_w;
    logic        e_we;
    logic [3:0]  e_be;
    logic [29:0] e_addr;
    logic [31:0] e_wd;
    last_w = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!(x_req && last_w != 1)) begin
        x_req = ($urandom_range(0, 3) == 0); x_we = $urandom_range(0, 1);
        x_addr = $urandom; x_wdata = $urandom;
      end
      if (!(d_req && last_w != 2)) begin
        d_req = $urandom_range(0, 1); d_we = $urandom_range(0, 1); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (!(i_req && last_w != 3)) begin
        i_req = ($urandom_range(0, 3) != 0); i_addr = $urandom;
      end
      #1;
      w  = exp_winner(exp_cnt, 4);
      w1 = exp_winner(exp_cnt1, 1);
      e_we = 1'b0; e_be = 4'h0; e_addr = '0; e_wd = '0;
      case (w)
        1: begin e_we = x_we; e_be = 4'hF; e_addr = x_addr[31:2]; e_wd = x_wdata; end
        2: begin e_we = d_we; e_be = d_be; e_addr = d_addr[31:2]; e_wd = d_wdata; end
        3: begin e_be = 4'hF; e_addr = i_addr[31:2]; end
        default: ;
      endcase
      tests++;
      if ({x_gnt, d_gnt, i_gnt} !== gvec(w)) begin
        fails++; $display("FAIL rand_gnt n=%0d: got %b want %b", n, {x_gnt, d_gnt, i_gnt}, gvec(w));
      end
      tests++;
      if ({x1_gnt, d1_gnt, i1_gnt} !== gvec(w1)) begin
        fails++; $display("FAIL rand_gnt_mw1 n=%0d: got %b want %b", n, {x1_gnt, d1_gnt, i1_gnt}, gvec(w1));
      end
      tests++;
      if (m_en !== (w != 0) || m_we !== e_we || m_be !== e_be || m_addr !== e_addr) begin
        fails++; $display("FAIL rand_mcmd n=%0d: got en=%b we=%b be=%h addr=%h want %b/%b/%h/%h",
                          n, m_en, m_we, m_be, m_addr, (w != 0), e_we, e_be, e_addr);
      end
      if (w != 3) begin
        tests++;
        if (m_wdata !== e_wd) begin
          fails++; $display("FAIL rand_mwdata n=%0d: got %h want %h", n, m_wdata, e_wd);
        end
      end
      tests++;
      if ({x_rvalid, d_rvalid, i_rvalid} !== gvec(exp_owner)) begin
        fails++; $display("FAIL rand_rvalid n=%0d: got %b want %b", n, {x_rvalid, d_rvalid, i_rvalid}, gvec(exp_owner));
      end
      tests++;
      if (x_rdata !== ((exp_owner == 1) ? exp_rd : 32'h0) ||
          d_rdata !== ((exp_owner == 2) ? exp_rd : 32'h0) ||
          i_rdata !== ((exp_owner == 3) ? exp_rd : 32'h0)) begin
        fails++; $display("FAIL rand_rdata n=%0d: got x=%h d=%h i=%h want owner=%0d data=%h",
                          n, x_rdata, d_rdata, i_rdata, exp_owner, exp_rd);
      end
      last_w = w;
      advance();
    end
    @(negedge clk);
    idle();
    advance();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    test_reset();
    test_fetch();
    test_starvation();
    test_data_write();
    test_loader();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
